// File: rtl/dual_port_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Read responses are routed back one cycle after the grant using a pending flag plus a port tag.
module dual_port_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    logic              last_b;
    logic              vld_p1;
    logic              tag_p1;
    logic [DATA_W-1:0] a_rdata_p1;
    logic [DATA_W-1:0] b_rdata_p1;

    // Stage p0: combinational grant and memory command
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (a_req && b_req) begin
                a_gnt = last_b;
                b_gnt = !last_b;
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        mem_en    = a_gnt | b_gnt;
        mem_we    = b_gnt ? b_we : (a_gnt & a_we);
        mem_addr  = b_gnt ? b_addr : a_addr;
        mem_wdata = b_gnt ? b_wdata : a_wdata;
    end

    // Stage p1: response routing; rst in the response cycle squashes a pending read
    assign a_rvalid = vld_p1 & ~tag_p1 & ~rst;
    assign b_rvalid = vld_p1 &  tag_p1 & ~rst;
    assign a_rdata  = a_rvalid ? mem_rdata : a_rdata_p1;
    assign b_rdata  = b_rvalid ? mem_rdata : b_rdata_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b       <= 1'b1;
            vld_p1       <= 1'b0;
            tag_p1       <= 1'b0;
            conflict_cnt <= '0;
            a_rdata_p1   <= '0;
            b_rdata_p1   <= '0;
        end else begin
            if (a_gnt || b_gnt)
                last_b <= b_gnt;
            vld_p1 <= mem_en & ~mem_we;
            tag_p1 <= b_gnt;
            if (a_req && b_req)
                conflict_cnt <= sat_inc(conflict_cnt);
            if (a_rvalid)
                a_rdata_p1 <= mem_rdata;
            if (b_rvalid)
                b_rdata_p1 <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dual_port_mem_arbiter.sv
// Randomized and directed bench for dual_port_mem_arbiter against a transaction-level reference model.
module tb_dual_port_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [15:0] conflict_cnt;

    dual_port_mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory device attached to the arbiter: one-cycle read latency
    logic [7:0] dmem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) dmem[mem_addr] <= mem_wdata;
            else        mem_rdata <= dmem[mem_addr];
        end
    end

    // Reference model state
    logic [7:0] ref_mem [256];
    bit         m_last_is_b;
    bit         m_rd_pend;
    bit         m_rd_port_b;
    logic [7:0] m_rd_data;
    logic [7:0] m_rdata_a, m_rdata_b;
    int         m_cc;
    bit         eg_a, eg_b;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of requests, check against the model, advance the model.
    task automatic step(input bit ra, input bit wa, input logic [7:0] aa, input logic [7:0] da,
                        input bit rb, input bit wb, input logic [7:0] ab, input logic [7:0] db,
                        input bit r);
        bit ev_a, ev_b;
        a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
        b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
        rst = r;
        #1;
        if (r) begin
            eg_a = 0; eg_b = 0;
        end else if (ra && rb) begin
            eg_a = m_last_is_b; eg_b = !m_last_is_b;
        end else begin
            eg_a = ra; eg_b = rb;
        end
        chk("a_gnt", 32'(a_gnt), 32'(eg_a));
        chk("b_gnt", 32'(b_gnt), 32'(eg_b));
        chk("mem_en", 32'(mem_en), 32'(eg_a | eg_b));
        chk("mem_we", 32'(mem_we), 32'((eg_a & wa) | (eg_b & wb)));
        if (eg_a) begin
            chk("mem_addr", 32'(mem_addr), 32'(aa));
            if (wa) chk("mem_wdata", 32'(mem_wdata), 32'(da));
        end
        if (eg_b) begin
            chk("mem_addr", 32'(mem_addr), 32'(ab));
            if (wb) chk("mem_wdata", 32'(mem_wdata), 32'(db));
        end
        ev_a = !r && m_rd_pend && !m_rd_port_b;
        ev_b = !r && m_rd_pend && m_rd_port_b;
        if (ev_a) m_rdata_a = m_rd_data;
        if (ev_b) m_rdata_b = m_rd_data;
        chk("a_rvalid", 32'(a_rvalid), 32'(ev_a));
        chk("b_rvalid", 32'(b_rvalid), 32'(ev_b));
        chk("a_rdata", 32'(a_rdata), 32'(m_rdata_a));
        chk("b_rdata", 32'(b_rdata), 32'(m_rdata_b));
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cc));
        @(posedge clk);
        if (r) begin
            m_last_is_b = 1; m_rd_pend = 0; m_rd_port_b = 0;
            m_rdata_a = 8'h00; m_rdata_b = 8'h00; m_cc = 0;
        end else begin
            if (ra && rb && m_cc < 16'hFFFF) m_cc++;
            m_rd_pend = 0;
            if (eg_a || eg_b) m_last_is_b = eg_b;
            if (eg_a) begin
                if (wa) ref_mem[aa] = da;
                else begin m_rd_pend = 1; m_rd_port_b = 0; m_rd_data = ref_mem[aa]; end
            end
            if (eg_b) begin
                if (wb) ref_mem[ab] = db;
                else begin m_rd_pend = 1; m_rd_port_b = 1; m_rd_data = ref_mem[ab]; end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, r);
    endtask

    initial begin
        bit         ha, hb, hwa, hwb, rr;
        logic [7:0] haa, hda, hab, hdb;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        dmem[8'h10] = 8'h5A; ref_mem[8'h10] = 8'h5A;
        m_rdata_a = 8'h00; m_rdata_b = 8'h00;
        m_last_is_b = 1; m_rd_pend = 0; m_rd_port_b = 0; m_cc = 0;
        rst = 1'b1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        @(negedge clk);

        // Reset with requests present: nothing granted, outputs cleared
        step(1, 1, 8'h01, 8'h11, 1, 0, 8'h02, 8'h00, 1);
        chk("rst_cnt", 32'(conflict_cnt), 32'h0);
        chk("rst_a_rdata", 32'(a_rdata), 32'h0);
        chk("rst_b_rdata", 32'(b_rdata), 32'h0);

        // Single read from A
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
        a_req = 0; #1;
        chk("r37_a_rvalid", 32'(a_rvalid), 32'h1);
        chk("r37_a_rdata", 32'(a_rdata), 32'h5A);
        chk("r37_b_rvalid", 32'(b_rvalid), 32'h0);
        idle(0);

        // Continuous dual requests from reset alternate A,B,...
        idle(1);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 8'(i), 8'h00, 1, 0, 8'(i + 8), 8'h00, 0);
            chk("r38_order", 32'(eg_a), 32'((i % 2) == 0));
        end
        chk("r38_cnt", 32'(conflict_cnt), 32'd6);
        idle(0);

        // A writes 0x20 while B reads 0x20
        idle(1);
        step(1, 1, 8'h20, 8'hC3, 1, 0, 8'h20, 8'h00, 0);
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0);
        idle(0);
        chk("r39_b_rdata", 32'(b_rdata), 32'hC3);

        // Alternating single reads, one response per cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 0, 8'(i * 3), 8'h00, 0, 0, 8'h00, 8'h00, 0);
            else            step(0, 0, 8'h00, 8'h00, 1, 0, 8'(i * 5), 8'h00, 0);
        end
        idle(0);

        // Reset right after a B read grant squashes the response
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h33, 8'h00, 0);
        idle(1);
        chk("r41_b_rdata", 32'(b_rdata), 32'h0);
        step(1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00, 0);
        chk("r41_first_a", 32'(eg_a), 32'h1);
        idle(0);

        // Randomized traffic with held requests and occasional reset
        ha = 0; hb = 0; hwa = 0; hwb = 0; haa = 0; hda = 0; hab = 0; hdb = 0;
        for (int i = 0; i < 600; i++) begin
            if (!ha && ($urandom % 3 != 0)) begin
                ha = 1; hwa = 1'($urandom); haa = 8'($urandom % 16); hda = 8'($urandom);
            end
            if (!hb && ($urandom % 3 != 0)) begin
                hb = 1; hwb = 1'($urandom); hab = 8'($urandom % 16); hdb = 8'($urandom);
            end
            rr = ($urandom % 60 == 0);
            step(ha, hwa, haa, hda, hb, hwb, hab, hdb, rr);
            if (eg_a) ha = 0;
            if (eg_b) hb = 0;
        end
        idle(0);

        // Saturating conflict counter
        idle(1);
        for (int i = 0; i < 65540; i++)
            step(1, 0, 8'(i), 8'h00, 1, 0, 8'(i + 1), 8'h00, 0);
        chk("r42_sat", 32'(conflict_cnt), 32'hFFFF);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
